adma_sys_ram: RTL and testbench

- System-memory model sitting directly downstream of the ADMA host-interface RAM port. It consumes address, write and data_out from the ADMA stimulus/engine side.
- Word-organised storage with a req/ack handshake and programmable access latency. Exercises the ADMA engine against realistic wait states.
- Flags misaligned and out-of-window accesses so the descriptor walker's error path can be tested.

---
 rtl/adma_sys_ram_if.sv | 35 +++
 rtl/adma_sys_ram.sv | 120 ++++++++++++
 tb/tb_adma_sys_ram.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/adma_sys_ram_if.sv
// rtl/adma_sys_ram_if.sv - request/response bus between the ADMA RAM port and the system-memory model
//
// Purpose: bundles the req/ack access bus of adma_sys_ram.
//   master : drives req, write, address, data_in (and byte_en), observes ack/data_out/addr_err/busy
//   slave  : the memory model side
// Optional: ADMA_SYS_RAM_BYTE_STROBE_EN adds byte_en[3:0].
interface adma_sys_ram_if;
   logic        req;
   logic        write;
   logic [63:0] address;
   logic [31:0] data_in;
`ifdef ADMA_SYS_RAM_BYTE_STROBE_EN
   logic [3:0]  byte_en;
`endif
   logic        ack;
   logic [31:0] data_out;
   logic        addr_err;
   logic        busy;

   modport master (
      output req, write, address, data_in,
`ifdef ADMA_SYS_RAM_BYTE_STROBE_EN
      output byte_en,
`endif
      input  ack, data_out, addr_err, busy
   );

   modport slave (
      input  req, write, address, data_in,
`ifdef ADMA_SYS_RAM_BYTE_STROBE_EN
      input  byte_en,
`endif
      output ack, data_out, addr_err, busy
   );
endinterface

// File: rtl/adma_sys_ram.sv
// rtl/adma_sys_ram.sv - word-organised system-memory model with programmable ack latency
//
// Purpose: services one access at a time from the ADMA host-interface RAM port.
//   A request captured in IDLE waits LATENCY cycles, then completes on the RESP
//   edge with a one-cycle ack. Misaligned / out-of-window accesses complete with
//   addr_err and leave memory and data_out untouched.
// Ports:
//   CLK   : system clock, rising edge
//   RESET : synchronous active-high reset
//   bus   : adma_sys_ram_if.slave (req, write, address, data_in, [byte_en],
//           ack, data_out, addr_err, busy)
// Optional: ADMA_SYS_RAM_BYTE_STROBE_EN enables per-byte write strobes.
module adma_sys_ram #(
   parameter logic [63:0] BASE_ADDR   = 64'd512,
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2
) (
   input logic          CLK,
   input logic          RESET,
   adma_sys_ram_if.slave bus
);
   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]  state;
   logic [3:0]  wait_cnt;
   logic        ack_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic        cap_write;
   logic [63:0] cap_addr;
   logic [31:0] cap_data;
`ifdef ADMA_SYS_RAM_BYTE_STROBE_EN
   logic [3:0]  cap_be;
`endif

   logic [31:0] mem [DEPTH_WORDS];

   // Range check works on the full 64-bit address; the explicit compare against
   // BASE_ADDR catches addresses below the window before the subtraction wraps.
   logic [63:0] offset;
   logic [63:0] index;
   logic        err;
   logic [AW-1:0] idx;

   assign offset = cap_addr - BASE_ADDR;
   assign index  = offset >> 2;
   assign err    = (cap_addr[1:0] != 2'b00) || (cap_addr < BASE_ADDR) ||
                   (index >= 64'(DEPTH_WORDS));
   assign idx    = index[AW-1:0];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  cap_write <= bus.write;
                  cap_addr  <= bus.address;
                  cap_data  <= bus.data_in;
`ifdef ADMA_SYS_RAM_BYTE_STROBE_EN
                  cap_be    <= bus.byte_en;
`endif
                  wait_cnt  <= 4'd0;
                  state     <= (LATENCY == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == LAT_LAST) begin
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            RESP: begin
               ack_q <= 1'b1;
               err_q <= err;
               if (!err && !cap_write) begin
                  rdata_q <= mem[idx];
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory contents survive reset; a reset on the RESP edge suppresses the write.
   always_ff @(posedge CLK) begin
      if (!RESET && state == RESP && cap_write && !err) begin
`ifdef ADMA_SYS_RAM_BYTE_STROBE_EN
         for (int b = 0; b < 4; b++) begin
            if (cap_be[b]) begin
               mem[idx][8*b +: 8] <= cap_data[8*b +: 8];
            end
         end
`else
         mem[idx] <= cap_data;
`endif
      end
   end

   assign bus.ack      = ack_q;
   assign bus.addr_err = err_q;
   assign bus.data_out = rdata_q;
   // The ack cycle is already back in IDLE, so busy also covers it.
   assign bus.busy     = (state != IDLE) || ack_q;
endmodule

// File: tb/tb_adma_sys_ram.sv
// tb/tb_adma_sys_ram.sv - directed self-checking bench for adma_sys_ram
module tb_adma_sys_ram;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   adma_sys_ram_if bus ();

   adma_sys_ram dut (
      .CLK   (clk),
      .RESET (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge; the request is captured on the next edge.
   task automatic do_access(input logic wr, input logic [63:0] addr, input logic [31:0] din,
                            input logic [3:0] be, output int lat, output int busy_n,
                            output logic [31:0] dout, output logic err);
      bus.req     = 1'b1;
      bus.write   = wr;
      bus.address = addr;
      bus.data_in = din;
`ifdef ADMA_SYS_RAM_BYTE_STROBE_EN
      bus.byte_en = be;
`else
      if (be != 4'hf) $display("note: byte_en ignored in this build");
`endif
      @(posedge clk);
      #1;
      bus.req     = 1'b0;
      bus.address = 64'hffff_ffff_ffff_fff3;
      bus.data_in = 32'h0bad_0bad;
      lat    = 0;
      busy_n = bus.busy ? 1 : 0;
      while (!bus.ack && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.busy) busy_n++;
      end
      dout = bus.data_out;
      err  = bus.addr_err;
   endtask

   initial begin
      int          lat;
      int          busy_n;
      logic [31:0] dout;
      logic        err;
      int          n_ack;
      int          ack_at [2];
      logic [31:0] second_data;
      logic        second_err;

      n_checks    = 0;
      n_pass      = 0;
      reset       = 1'b1;
      bus.req     = 1'b0;
      bus.write   = 1'b0;
      bus.address = 64'd0;
      bus.data_in = 32'd0;
`ifdef ADMA_SYS_RAM_BYTE_STROBE_EN
      bus.byte_en = 4'hf;
`endif
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_ack", 64'(bus.ack), 64'd0);
      check("rst_err", 64'(bus.addr_err), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_dout", 64'(bus.data_out), 64'd0);

      // 24 writes, LATENCY=2: ack 3 edges after capture, busy for 4 cycles
      for (int i = 1; i <= 24; i++) begin
         do_access(1'b1, 64'(512 + 4 * i), 32'(4 * i), 4'hf, lat, busy_n, dout, err);
         check($sformatf("wr_lat[%0d]", i), 64'(lat), 64'd3);
         check($sformatf("wr_busy[%0d]", i), 64'(busy_n), 64'd4);
         check($sformatf("wr_err[%0d]", i), 64'(err), 64'd0);
      end

      // word 0 holds power-on contents; only legality is checked
      do_access(1'b0, 64'd512, 32'd0, 4'hf, lat, busy_n, dout, err);
      check("rd512_lat", 64'(lat), 64'd3);
      check("rd512_err", 64'(err), 64'd0);

      for (int i = 1; i <= 24; i++) begin
         do_access(1'b0, 64'(512 + 4 * i), 32'd0, 4'hf, lat, busy_n, dout, err);
         check($sformatf("rd_data[%0d]", i), 64'(dout), 64'(4 * i));
         check($sformatf("rd_err[%0d]", i), 64'(err), 64'd0);
      end

      // misaligned, below window, one past the end
      do_access(1'b0, 64'd514, 32'd0, 4'hf, lat, busy_n, dout, err);
      check("mis_err", 64'(err), 64'd1);
      check("mis_dout", 64'(dout), 64'd96);
      do_access(1'b0, 64'd508, 32'd0, 4'hf, lat, busy_n, dout, err);
      check("low_err", 64'(err), 64'd1);
      check("low_dout", 64'(dout), 64'd96);
      do_access(1'b0, 64'd1536, 32'd0, 4'hf, lat, busy_n, dout, err);
      check("high_err", 64'(err), 64'd1);
      check("high_dout", 64'(dout), 64'd96);
      check("high_lat", 64'(lat), 64'd3);
      do_access(1'b0, 64'd0, 32'd0, 4'hf, lat, busy_n, dout, err);
      check("zero_err", 64'(err), 64'd1);
      do_access(1'b0, 64'd516, 32'd0, 4'hf, lat, busy_n, dout, err);
      check("rd516_data", 64'(dout), 64'd4);
      check("rd516_err", 64'(err), 64'd0);

      // write 520 with req held, then read 520 on the re-trigger
      bus.req     = 1'b1;
      bus.write   = 1'b1;
      bus.address = 64'd520;
      bus.data_in = 32'hdead_beef;
`ifdef ADMA_SYS_RAM_BYTE_STROBE_EN
      bus.byte_en = 4'hf;
`endif
      @(posedge clk);
      #1;
      bus.write   = 1'b0;
      bus.data_in = 32'h1234_5678;
      n_ack       = 0;
      ack_at[0]   = -1;
      ack_at[1]   = -1;
      second_data = 32'd0;
      second_err  = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (bus.ack) begin
            if (n_ack < 2) ack_at[n_ack] = c;
            n_ack++;
            if (n_ack == 2) begin
               second_data = bus.data_out;
               second_err  = bus.addr_err;
               bus.req     = 1'b0;
            end
         end
      end
      bus.req = 1'b0;
      check("held_n_ack", 64'(n_ack), 64'd2);
      check("held_first", 64'(ack_at[0]), 64'd3);
      check("held_second", 64'(ack_at[1]), 64'd7);
      check("held_data", 64'(second_data), 64'hdead_beef);
      check("held_err", 64'(second_err), 64'd0);

      // reset during WAIT aborts the write to 524
      bus.req     = 1'b1;
      bus.write   = 1'b1;
      bus.address = 64'd524;
      bus.data_in = 32'h5555_5555;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      reset   = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_busy", 64'(bus.busy), 64'd0);
      n_ack = 0;
      for (int c = 0; c < 8; c++) begin
         if (bus.ack) n_ack++;
         @(posedge clk);
         #1;
      end
      check("abort_no_ack", 64'(n_ack), 64'd0);
      do_access(1'b0, 64'd524, 32'd0, 4'hf, lat, busy_n, dout, err);
      check("abort_rd", 64'(dout), 64'd12);
      check("abort_lat", 64'(lat), 64'd3);

`ifdef ADMA_SYS_RAM_BYTE_STROBE_EN
      do_access(1'b1, 64'd528, 32'haabb_ccdd, 4'hf, lat, busy_n, dout, err);
      do_access(1'b1, 64'd528, 32'h1122_3344, 4'b0101, lat, busy_n, dout, err);
      check("be_wr_err", 64'(err), 64'd0);
      do_access(1'b1, 64'd528, 32'hffff_ffff, 4'b0000, lat, busy_n, dout, err);
      check("be_zero_err", 64'(err), 64'd0);
      check("be_zero_lat", 64'(lat), 64'd3);
      do_access(1'b0, 64'd528, 32'd0, 4'b0000, lat, busy_n, dout, err);
      check("be_rd", 64'(dout), 64'haa22_cc44);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
